// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU/RAM interface types. word_t is the 32-bit data
//                word; ramstate_t is the status the RAM reports back to its
//                bus master each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage
`default_nettype wire

// File: rtl/ram_requester.sv
`default_nettype none
// ============================================================================
//  Module      : ram_requester
//  Description : Bus-master end of the RAM interface. Arbitrates round-robin
//                between the instruction port and the data port, holds a
//                registered request on the RAM side until ACCESS, ERROR or a
//                timeout, then gives the winner a one-cycle completion.
//  Ports       : CLK, nRST            clock, synchronous active-low reset
//                iREN/iaddr           instruction read request
//                iwait/iload          instruction pending flag / read data
//                dREN/dWEN/daddr/dstore  data request
//                dwait/dload          data pending flag / read data
//                err                  pulse with a failed completion
//                ramREN/ramWEN/ramaddr/ramstore  registered RAM request
//                ramload/ramstate     RAM read data / status
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_requester
    import cpu_types_pkg::*;
#(
    parameter int    TIMEOUT = 16,
    parameter word_t BAD     = 32'hBAD1BAD1
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      err,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic       c_GNT_I    = 1'b0;
    localparam logic       c_GNT_D    = 1'b1;
    // Last value cnt reaches before the transaction is forced to complete.
    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_gnt;
    logic       r_last;
    logic [7:0] r_cnt;

    logic w_ireq;
    logic w_dreq;
    logic w_any_req;
    logic w_grant_d;
    logic w_illegal;
    logic w_done_ok;
    logic w_done_bad;

    assign w_ireq    = iREN;
    assign w_dreq    = dREN | dWEN;
    assign w_any_req = w_ireq | w_dreq;
    // D wins when alone, or on a tie when I was served last.
    assign w_grant_d = w_dreq & (~w_ireq | (r_last == c_GNT_I));
    assign w_illegal = dREN & dWEN;
    // ACCESS takes priority over ERROR/timeout arriving in the same cycle.
    assign w_done_ok  = (ramstate == ACCESS);
    assign w_done_bad = (ramstate == ERROR) | (r_cnt == c_CNT_LAST);

    // Wait depends only on the request inputs and the registered state.
    assign iwait = iREN   & ~((r_state == RESP) & (r_gnt == c_GNT_I));
    assign dwait = w_dreq & ~((r_state == RESP) & (r_gnt == c_GNT_D));

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    // An illegal read+write never reaches the RAM.
                    w_next_state = (w_grant_d & w_illegal) ? RESP : REQ;
                end
            end
            REQ: begin
                if (w_done_ok | w_done_bad) begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_gnt    <= c_GNT_I;
            r_last   <= c_GNT_I;
            r_cnt    <= 8'd0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            iload    <= '0;
            dload    <= '0;
            err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_cnt <= 8'd0;
                        if (w_grant_d) begin
                            r_gnt    <= c_GNT_D;
                            ramaddr  <= daddr;
                            ramstore <= dstore;
                            if (w_illegal) begin
                                ramREN <= 1'b0;
                                ramWEN <= 1'b0;
                                dload  <= BAD;
                                err    <= 1'b1;
                            end else begin
                                ramREN <= dREN;
                                ramWEN <= dWEN;
                            end
                        end else begin
                            r_gnt   <= c_GNT_I;
                            ramaddr <= iaddr;
                            ramREN  <= 1'b1;
                            ramWEN  <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (w_done_ok) begin
                        if (r_gnt == c_GNT_I) iload <= ramload;
                        else                  dload <= ramload;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        err    <= 1'b0;
                    end else if (w_done_bad) begin
                        if (r_gnt == c_GNT_I) iload <= BAD;
                        else                  dload <= BAD;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        err    <= 1'b1;
                    end
                end
                RESP: begin
                    r_last <= r_gnt;
                    err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_requester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_requester
//  Description : Self-checking bench for ram_requester. A transaction-level
//                reference model predicts each completion (port, cycle, load,
//                err) into a scoreboard queue; a monitor pops and compares
//                whenever a requester's wait drops. A behavioural RAM answers
//                with a scripted latency / error / no-answer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_requester;
    import cpu_types_pkg::*;

    localparam int          T    = 16;
    localparam logic [31:0] BADV = 32'hBAD1BAD1;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dwait;
    logic [31:0] dload;
    logic        err;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore;
    logic [31:0] rl = '0;
    ramstate_t   rs = FREE;

    always #5 CLK = ~CLK;

    ram_requester #(.TIMEOUT(T), .BAD(BADV)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload), .err(err),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(rl), .ramstate(rs)
    );

    typedef struct packed {
        bit          port;     // 0 = I, 1 = D
        bit          ren;
        bit          wen;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    typedef struct packed {
        bit          port;
        bit          chk_load;
        logic [31:0] load;
        bit          err;
        int          cyc;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sbq[$];

    // Reference model state
    logic [31:0] ref_mem [logic [31:0]];
    bit          ref_last = 1'b0;

    // RAM behaviour control
    logic [31:0] ram_mem [logic [31:0]];
    int          ram_mode = 0;     // 0 ACCESS after delay, 1 ERROR after delay, 2 never
    int          ram_delay = 0;
    int          rcnt = 0;
    logic [65:0] rq_lat = '0;
    bit          illegal_active = 1'b0;
    bit          i_act = 1'b0;
    bit          d_act = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hC0DE0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural RAM ----------------
    always @(negedge CLK) begin
        if (illegal_active) check("no_enable_illegal", {30'd0, ramREN, ramWEN}, 32'd0);
        if (ramREN || ramWEN) begin
            if (rcnt == 0) rq_lat = {ramREN, ramWEN, ramaddr, ramstore};
            else check("ram_stable", {31'd0, ({ramREN, ramWEN, ramaddr, ramstore} == rq_lat)}, 32'd1);
            if (ram_mode != 2 && rcnt == ram_delay) begin
                if (ram_mode == 0) begin
                    rs = ACCESS;
                    if (ramWEN) begin
                        ram_mem[ramaddr] = ramstore;
                        rl = $urandom;
                    end else begin
                        rl = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : dflt(ramaddr);
                    end
                end else begin
                    rs = ERROR;
                    rl = $urandom;
                end
            end else begin
                rs = BUSY;
                rl = $urandom;
            end
            rcnt++;
        end else begin
            rs   = FREE;
            rcnt = 0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic completion(input bit port, input logic [31:0] ld);
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_completion: port %0d at cycle %0d, none expected", port, cyc);
            return;
        end
        e = sbq.pop_front();
        check("port", {31'd0, port}, {31'd0, e.port});
        check("done_cycle", cyc, e.cyc);
        check("err", {31'd0, err}, {31'd0, e.err});
        if (e.chk_load) check("load", ld, e.load);
        check("enables_in_resp", {30'd0, ramREN, ramWEN}, 32'd0);
    endtask

    always @(negedge CLK) begin
        bit ci, cd;
        ci = iREN && !iwait;
        cd = (dREN || dWEN) && !dwait;
        if (nRST) begin
            if (ci) completion(1'b0, iload);
            if (cd) completion(1'b1, dload);
            if (!ci && !cd) check("err_idle", {31'd0, err}, 32'd0);
        end
    end

    // ---------------- reference model ----------------
    task automatic predict(input txn_t t, input int issue, output exp_t e);
        bit ill;
        ill        = t.port && t.ren && t.wen;
        e.port     = t.port;
        e.chk_load = 1'b1;
        e.load     = BADV;
        e.err      = 1'b1;
        if (ill)                 e.cyc = issue + 1;
        else if (ram_mode == 2)  e.cyc = issue + T + 1;
        else begin
            e.cyc = issue + 2 + ram_delay;
            if (ram_mode == 0) begin
                e.err = 1'b0;
                if (t.wen) begin
                    e.chk_load     = 1'b0;
                    ref_mem[t.addr] = t.data;
                end else begin
                    e.load = ref_mem.exists(t.addr) ? ref_mem[t.addr] : dflt(t.addr);
                end
            end
        end
        ref_last = t.port;
    endtask

    function automatic txn_t mk(input bit p, input bit r, input bit w,
                                input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.port = p; t.ren = r; t.wen = w; t.addr = a; t.data = d;
        return t;
    endfunction

    function automatic txn_t rand_txn(input bit p);
        int r;
        r = $urandom_range(0, 7);
        if (!p) return mk(1'b0, 1'b1, 1'b0, 32'($urandom_range(0, 15)) << 2, 32'd0);
        return mk(1'b1, (r < 4) || (r == 7), (r >= 4), 32'($urandom_range(0, 15)) << 2, $urandom);
    endfunction

    task automatic drive(input txn_t t);
        if (!t.port) begin
            iREN = 1'b1; iaddr = t.addr; i_act = 1'b1;
        end else begin
            dREN = t.ren; dWEN = t.wen; daddr = t.addr; dstore = t.data; d_act = 1'b1;
        end
    endtask

    // Called just after a negedge while the DUT is IDLE; a is I, b is D on a tie.
    task automatic start(input txn_t a, input bit two, input txn_t b, input int mode, input int delay);
        exp_t e;
        int   issue;
        ram_mode  = mode;
        ram_delay = delay;
        issue     = cyc;
        drive(a);
        if (two) begin
            drive(b);
            if (ref_last == 1'b0) begin
                predict(b, issue, e);     sbq.push_back(e);
                predict(a, e.cyc + 1, e); sbq.push_back(e);
            end else begin
                predict(a, issue, e);     sbq.push_back(e);
                predict(b, e.cyc + 1, e); sbq.push_back(e);
            end
        end else begin
            predict(a, issue, e);
            sbq.push_back(e);
            illegal_active = a.port && a.ren && a.wen;
        end
    endtask

    task automatic wait_done();
        bit di, dd;
        for (int k = 0; k < 300 && (i_act || d_act); k++) begin
            @(negedge CLK);
            di = i_act && !iwait;
            dd = d_act && !dwait;
            #1;
            if (di) begin iREN = 1'b0; i_act = 1'b0; end
            if (dd) begin dREN = 1'b0; dWEN = 1'b0; d_act = 1'b0; end
        end
        illegal_active = 1'b0;
        if (i_act || d_act) begin
            total++;
            bad++;
            $display("FAIL txn_bound: request still pending after 300 cycles (i=%0d d=%0d)", i_act, d_act);
            iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; i_act = 1'b0; d_act = 1'b0;
            nRST = 1'b0;
            @(negedge CLK); #1;
            nRST = 1'b1;
            sbq.delete();
            ref_last = 1'b0;
        end
    endtask

    initial begin
        exp_t e;
        txn_t t;
        ram_mem[32'h40] = 32'h8C220004;
        ref_mem[32'h40] = 32'h8C220004;

        // Reset values with no requests present
        repeat (2) @(negedge CLK);
        check("rst_ramREN",   {31'd0, ramREN}, 32'd0);
        check("rst_ramWEN",   {31'd0, ramWEN}, 32'd0);
        check("rst_ramaddr",  ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        check("rst_iload",    iload, 32'd0);
        check("rst_dload",    dload, 32'd0);
        check("rst_err",      {31'd0, err}, 32'd0);
        check("rst_waits",    {30'd0, iwait, dwait}, 32'd0);

        // Contention from reset release: D write wins, then I reads it back
        #1;
        start(mk(1'b0, 1'b1, 1'b0, 32'h80, 32'd0), 1'b1,
              mk(1'b1, 1'b0, 1'b1, 32'h80, 32'h12345678), 0, 1);
        nRST = 1'b1;
        wait_done();

        // Single instruction read
        @(negedge CLK); #1;
        start(mk(1'b0, 1'b1, 1'b0, 32'h40, 32'd0), 1'b0, '0, 0, 1);
        wait_done();

        // Timeout, RAM error in second REQ cycle, illegal request, late ACCESS
        @(negedge CLK); #1;
        start(mk(1'b1, 1'b1, 1'b0, 32'h48, 32'd0), 1'b0, '0, 2, 0);
        wait_done();
        @(negedge CLK); #1;
        start(mk(1'b1, 1'b1, 1'b0, 32'h4C, 32'd0), 1'b0, '0, 1, 1);
        wait_done();
        @(negedge CLK); #1;
        start(mk(1'b1, 1'b1, 1'b1, 32'h50, 32'h55AA55AA), 1'b0, '0, 0, 0);
        wait_done();
        @(negedge CLK); #1;
        start(mk(1'b1, 1'b1, 1'b0, 32'h40, 32'd0), 1'b0, '0, 0, T - 1);
        wait_done();

        // Reset in the middle of REQ, request held throughout
        @(negedge CLK); #1;
        ram_mode = 2;
        t = mk(1'b1, 1'b1, 1'b0, 32'h44, 32'd0);
        drive(t);
        repeat (3) @(negedge CLK);
        #1 nRST = 1'b0;
        @(negedge CLK);
        check("midrst_ramREN",  {31'd0, ramREN}, 32'd0);
        check("midrst_ramaddr", ramaddr, 32'd0);
        check("midrst_dload",   dload, 32'd0);
        check("midrst_err",     {31'd0, err}, 32'd0);
        check("midrst_dwait",   {31'd0, dwait}, 32'd1);
        #1 nRST = 1'b1;
        ram_mode  = 0;
        ram_delay = 2;
        ref_last  = 1'b0;
        predict(t, cyc, e);
        sbq.push_back(e);
        wait_done();

        // Randomised traffic
        for (int n = 0; n < 70; n++) begin
            int mode, delay, r;
            bit two, p;
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            @(negedge CLK); #1;
            r     = $urandom_range(0, 19);
            mode  = (r < 14) ? 0 : ((r < 18) ? 1 : 2);
            delay = ($urandom_range(0, 9) == 0) ? T - 1 : $urandom_range(0, 4);
            two   = ($urandom_range(0, 3) == 0);
            p     = 1'($urandom_range(0, 1));
            if (two) start(rand_txn(1'b0), 1'b1, rand_txn(1'b1), mode, delay);
            else     start(rand_txn(p), 1'b0, '0, mode, delay);
            wait_done();
        end

        repeat (5) @(negedge CLK);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
